// File: rtl/pipe_rot_pkg.sv
// Shared types and a reference rotate function for the pipelined circular rotator.
package pipe_rot_pkg;

   // Widest word the reference function handles.
   localparam int unsigned MAX_W = 64;

   typedef enum logic {
      ROT_LEFT  = 1'b0,
      ROT_RIGHT = 1'b1
   } rot_dir_t;

   // Rotate the low n bits of x by s positions. Bits at and above n are returned as 0.
   function automatic logic [MAX_W-1:0] rot_fn(
      input logic [MAX_W-1:0] x,
      input int unsigned      s,
      input rot_dir_t         dir,
      input int unsigned      n
   );
      logic [MAX_W-1:0] y;
      int unsigned      dst;
      y = '0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < n) begin
            if (dir == ROT_LEFT) dst = (i + s) % n;
            else                 dst = (i + n - (s % n)) % n;
            y[dst] = x[i];
         end
      end
      return y;
   endfunction

endpackage

// File: rtl/circular_rotator_stage.sv
// One pipeline slice: conditionally rotates by 2^K, registers the result with its
// remaining amount/direction, and provides the valid/ready handshake for the slice.
module circular_rotator_stage
   import pipe_rot_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned K  = 0,
   parameter int unsigned AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic [AW-1:0] in_amount,
   input  rot_dir_t      in_dir,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic [AW-1:0] out_amount,
   output rot_dir_t      out_dir
);

   localparam int unsigned S = 1 << K;

   logic          valid_q;
   logic [N-1:0]  data_q;
   logic [AW-1:0] amount_q;
   rot_dir_t      dir_q;

   logic [N-1:0]  rot_left;
   logic [N-1:0]  rot_right;
   logic [N-1:0]  data_d;

   // Fixed-distance rotates are pure wiring; S never exceeds N/2 because K < AW.
   assign rot_left  = {in_data[N-S-1:0], in_data[N-1:N-S]};
   assign rot_right = {in_data[S-1:0],   in_data[N-1:S]};
   assign data_d    = in_amount[K] ? ((in_dir == ROT_RIGHT) ? rot_right : rot_left)
                                   : in_data;

   // The slice can take a word when it is empty or its contents move on this cycle.
   assign in_ready = !valid_q || out_ready;

   // Valid follows upstream on every load (bubbles included); payload loads only with a real word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         amount_q <= '0;
         dir_q    <= ROT_LEFT;
      end else if (in_ready) begin
         valid_q <= in_valid;
         if (in_valid) begin
            data_q   <= data_d;
            amount_q <= in_amount;
            dir_q    <= in_dir;
         end
      end
   end

   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_amount = amount_q;
   assign out_dir    = dir_q;

endmodule

// File: rtl/pipelined_circular_rotator.sv
// Run-time-amount barrel rotator, one register stage per bit of the rotate amount,
// with valid/ready handshakes on both the upstream and downstream sides.
module pipelined_circular_rotator
   import pipe_rot_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic [N-1:0]         up_data,
   input  logic [$clog2(N)-1:0] up_amount,
   input  logic                 up_dir,
   output logic                 down_valid,
   input  logic                 down_ready,
   output logic [N-1:0]         down_data
);

   localparam int unsigned AW = $clog2(N);

   if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_width
      $error("pipelined_circular_rotator: N must be a power of two and at least 2");
   end

   // Index k is the input of stage k; index AW is the output of the last stage.
   logic [AW:0]   valid_c;
   logic [AW:0]   ready_c;
   logic [N-1:0]  data_c   [AW+1];
   logic [AW-1:0] amount_c [AW+1];
   rot_dir_t      dir_c    [AW+1];

   assign valid_c[0]  = up_valid;
   assign data_c[0]   = up_data;
   assign amount_c[0] = up_amount;
   assign dir_c[0]    = rot_dir_t'(up_dir);
   assign up_ready    = ready_c[0];

   assign ready_c[AW] = down_ready;
   assign down_valid  = valid_c[AW];
   assign down_data   = data_c[AW];

   // Amount and direction leaving the last stage have no consumer.
   logic unused_tail;
   assign unused_tail = ^{amount_c[AW], dir_c[AW]};

   for (genvar gi = 0; gi < AW; gi++) begin : g_stage
      circular_rotator_stage #(
         .N  (N),
         .K  (gi),
         .AW (AW)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .in_valid   (valid_c[gi]),
         .in_ready   (ready_c[gi]),
         .in_data    (data_c[gi]),
         .in_amount  (amount_c[gi]),
         .in_dir     (dir_c[gi]),
         .out_valid  (valid_c[gi+1]),
         .out_ready  (ready_c[gi+1]),
         .out_data   (data_c[gi+1]),
         .out_amount (amount_c[gi+1]),
         .out_dir    (dir_c[gi+1])
      );
   end

endmodule

// File: tb/tb_pipelined_circular_rotator.sv
// Self-checking bench for pipelined_circular_rotator (N=8): directed vectors with
// literal expectations plus a queue-based scoreboard checked on every output transfer.
module tb_pipelined_circular_rotator;

   localparam int N  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          up_valid = 1'b0;
   logic          up_ready;
   logic [N-1:0]  up_data = '0;
   logic [AW-1:0] up_amount = '0;
   logic          up_dir = 1'b0;
   logic          down_valid;
   logic          down_ready = 1'b1;
   logic [N-1:0]  down_data;

   int n_cmp = 0;
   int n_bad = 0;
   int n_out = 0;

   logic [N-1:0] exp_q [$];
   logic         stall_prev = 1'b0;
   logic [N-1:0] stall_data = '0;

   pipelined_circular_rotator #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_amount  (up_amount),
      .up_dir     (up_dir),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data)
   );

   always #5 clk = ~clk;

   // Rotation from first principles: duplicate the word and take an N-bit window.
   function automatic logic [N-1:0] model_rot(input logic [N-1:0] x, input int s, input logic right);
      logic [2*N-1:0] w;
      w = {x, x};
      if (right) begin
         w = w >> s;
         return w[N-1:0];
      end
      w = w << s;
      return w[2*N-1:N];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every output transfer must match the oldest accepted word's rotation,
   // and a stalled output must hold. Reset discards everything in flight.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", {31'd0, down_valid}, 32'd1);
            check("hold_data", {24'd0, down_data}, {24'd0, stall_data});
         end
         if (down_valid && down_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_out: got %0h expected no output", down_data);
            end else begin
               check("scoreboard", {24'd0, down_data}, {24'd0, exp_q.pop_front()});
            end
            n_out++;
         end
         if (up_valid && up_ready)
            exp_q.push_back(model_rot(up_data, int'(up_amount), up_dir));
         stall_prev = down_valid && !down_ready;
         stall_data = down_data;
      end
   end

   // One word into an empty pipeline; checks the literal result and the latency.
   task automatic single(input logic [7:0] d, input int amt, input logic dir, input logic [7:0] exp);
      int lat;
      check("model_pin", {24'd0, model_rot(d, amt, dir)}, {24'd0, exp});
      @(posedge clk); #1;
      up_valid = 1'b1; up_data = d; up_amount = AW'(amt); up_dir = dir; down_ready = 1'b1;
      #1 check("single_up_ready", {31'd0, up_ready}, 32'd1);
      @(posedge clk); #1;
      up_valid = 1'b0;
      lat = 1;
      while (!down_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check("single_latency", lat, AW);
      check("single_data", {24'd0, down_data}, {24'd0, exp});
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idx;
      int acc;
      int cyc;
      logic r;
      logic [7:0] held;
      logic [7:0] bp_words [6];

      // Reset and idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_down_valid", {31'd0, down_valid}, 32'd0);
      check("rst_down_data", {24'd0, down_data}, 32'd0);
      check("rst_up_ready", {31'd0, up_ready}, 32'd1);

      // Basic rotations
      single(8'hA3, 3, 1'b1, 8'h74);
      single(8'hA3, 3, 1'b0, 8'h1D);
      single(8'hA3, 0, 1'b0, 8'hA3);
      single(8'hA3, 7, 1'b1, 8'h47);
      single(8'h81, 4, 1'b0, 8'h18);
      repeat (3) @(posedge clk);

      // Streaming: 8 back-to-back words, left by 1, outputs on consecutive cycles
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               @(posedge clk); #1;
               up_valid = 1'b1; up_data = 8'(i + 1); up_amount = 3'd1; up_dir = 1'b0;
               #1 check("stream_up_ready", {31'd0, up_ready}, 32'd1);
            end
            @(posedge clk); #1;
            up_valid = 1'b0;
         end
         begin
            int w;
            w = 0;
            @(posedge clk); #1;
            while (!down_valid && w < 20) begin
               @(posedge clk); #1;
               w++;
            end
            for (int j = 0; j < 8; j++) begin
               check("stream_valid", {31'd0, down_valid}, 32'd1);
               check("stream_data", {24'd0, down_data}, 32'((j + 1) * 2));
               @(posedge clk); #1;
            end
         end
      join
      repeat (4) @(posedge clk);

      // Backpressure: 6 words, output stalled for 5 cycles
      for (int i = 0; i < 6; i++) bp_words[i] = 8'(8'h11 * (i + 1));
      acc = n_out;
      idx = 0;
      held = '0;
      @(posedge clk); #1;
      down_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         up_valid = 1'b1; up_data = bp_words[idx]; up_amount = 3'd2; up_dir = 1'b1;
         #1 r = up_ready;
         check("bp_up_ready", {31'd0, r}, (c < 3) ? 32'd1 : 32'd0);
         if (c == 3) held = down_data;
         if (c == 4) check("bp_stable", {24'd0, down_data}, {24'd0, held});
         @(posedge clk); #1;
         if (r) idx++;
      end
      down_ready = 1'b1;
      cyc = 0;
      while (idx < 6 && cyc < 50) begin
         up_valid = 1'b1; up_data = bp_words[idx]; up_amount = 3'd2; up_dir = 1'b1;
         #1 r = up_ready;
         @(posedge clk); #1;
         if (r) idx++;
         cyc++;
      end
      up_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("bp_out_count", n_out - acc, 6);
      check("bp_drained", exp_q.size(), 0);

      // Mid-run reset flushes in-flight words
      @(posedge clk); #1;
      up_valid = 1'b1; up_data = 8'h5A; up_amount = 3'd1; up_dir = 1'b0;
      @(posedge clk); #1;
      up_data = 8'hC3;
      @(posedge clk); #1;
      up_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, down_valid}, 32'd0);
      check("mid_rst_data", {24'd0, down_data}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 check("mid_rst_up_ready", {31'd0, up_ready}, 32'd1);
      acc = n_out;
      repeat (6) @(posedge clk);
      #1 check("mid_rst_no_stale", n_out - acc, 0);

      // Random traffic with a reset pulse part-way
      acc = 0;
      cyc = 0;
      r = 1'b1;
      while (acc < 10000 && cyc < 60000) begin
         @(posedge clk); #1;
         if (cyc == 9000) rst = 1'b1;
         if (cyc == 9002) rst = 1'b0;
         if (!(up_valid && !r)) begin
            up_valid  = ($urandom_range(0, 3) != 0);
            up_data   = 8'($urandom);
            up_amount = 3'($urandom_range(0, 7));
            up_dir    = 1'($urandom_range(0, 1));
         end
         down_ready = ($urandom_range(0, 3) != 0);
         #1 r = up_ready && !rst;
         if (up_valid && r) acc++;
         cyc++;
      end
      @(posedge clk); #1;
      up_valid = 1'b0;
      down_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("rand_accepts", {31'd0, acc >= 10000}, 32'd1);
      check("rand_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
